rsa_modexp_core: RTL

- Byte-wide Montgomery modular-exponentiation engine. It computes result = M^E mod N for the RSA peripheral.
- Consumes the register-block outputs: start/stop command bits, plain text, exponent, modulus and R^2 mod N.
- Returns the encrypted data byte and completion status for read-back.
- Encrypt and decrypt are the same operation; software selects the direction through the exponent it loads.

---
 rtl/rsa_pkg.sv | 22 ++
 rtl/rsa_mont_mul.sv | 63 ++++++
 rtl/rsa_modexp_core.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation slice.
package rsa_pkg;

   localparam int unsigned RSA_WIDTH         = 8;
   localparam int unsigned RSA_MONPRO_CYCLES = RSA_WIDTH + 2;

   localparam int unsigned CMD_START_BIT = 0;
   localparam int unsigned CMD_STOP_BIT  = 1;
   localparam int unsigned STAT_DONE_BIT = 0;
   localparam int unsigned STAT_ERR_BIT  = 1;

   typedef enum logic [2:0] {
      StIdle,
      StPreM,
      StPreX,
      StSqr,
      StMul,
      StPost,
      StDone
   } modexp_state_t;

endpackage

// File: rtl/rsa_mont_mul.sv
// Bit-serial Montgomery product p = a*b*2^-WIDTH mod n.
// done pulses WIDTH+1 cycles after start; p is valid while done is high.
module rsa_mont_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             done
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] a_q, b_q, n_q;
   logic [WIDTH+1:0] t_q, t_add, t_odd;
   logic [CW-1:0]    cnt_q;
   logic             run_q, done_q;

   always_comb begin
      t_add = t_q + (a_q[0] ? {2'b00, b_q} : '0);
      t_odd = t_add[0] ? (t_add + {2'b00, n_q}) : t_add;
   end

   // Final conditional subtract is done combinationally in the cycle done is high.
   assign p    = (t_q >= {2'b00, n_q}) ? WIDTH'(t_q - {2'b00, n_q}) : t_q[WIDTH-1:0];
   assign done = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         t_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            t_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
         end else if (run_q) begin
            t_q   <= t_odd >> 1;
            a_q   <= a_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rsa_modexp_core.sv
// Montgomery left-to-right square-and-multiply engine: result = M^E mod N.
// Define RSA_OPERAND_CHECK_EN to reject bad operands at launch with error_o.
module rsa_modexp_core
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [WIDTH-1:0] plain_text_i,
   input  logic [WIDTH-1:0] exp_i,
   input  logic [WIDTH-1:0] mod_i,
   input  logic [WIDTH-1:0] mont_const_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o
);

   localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   modexp_state_t    state_q;
   logic             start_q, mul_start_q, busy_q, done_q, error_q;
   logic [WIDTH-1:0] m_q, e_q, n_q, r2_q, mb_q, xb_q, result_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] mul_a, mul_b, mul_p;
   logic             mul_done, launch, operand_bad;

   assign launch = start_i & ~start_q & ~stop_i & ((state_q == StIdle) || (state_q == StDone));

`ifdef RSA_OPERAND_CHECK_EN
   assign operand_bad = ~mod_i[0] | (mod_i < WIDTH'(3)) | (plain_text_i >= mod_i);
`else
   assign operand_bad = 1'b0;
`endif

   always_comb begin
      mul_a = xb_q;
      mul_b = xb_q;
      case (state_q)
         StPreM:  begin mul_a = m_q;       mul_b = r2_q; end
         StPreX:  begin mul_a = WIDTH'(1); mul_b = r2_q; end
         StMul:   mul_b = mb_q;
         StPost:  mul_b = WIDTH'(1);
         default: ;
      endcase
   end

   rsa_mont_mul #(.WIDTH(WIDTH)) u_mont_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (stop_i),
      .start (mul_start_q),
      .a     (mul_a),
      .b     (mul_b),
      .n     (n_q),
      .p     (mul_p),
      .done  (mul_done)
   );

   // Each MonPro result is consumed on the same edge that issues the next one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         start_q     <= 1'b0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         m_q         <= '0;
         e_q         <= '0;
         n_q         <= '0;
         r2_q        <= '0;
         mb_q        <= '0;
         xb_q        <= '0;
         result_q    <= '0;
         k_q         <= '0;
      end else begin
         start_q     <= start_i;
         mul_start_q <= 1'b0;
         if (stop_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else if (launch) begin
            m_q     <= plain_text_i;
            e_q     <= exp_i;
            n_q     <= mod_i;
            r2_q    <= mont_const_i;
            k_q     <= KW'(WIDTH - 1);
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (operand_bad) begin
               state_q  <= StDone;
               done_q   <= 1'b1;
               error_q  <= 1'b1;
               result_q <= '0;
            end else begin
               state_q     <= StPreM;
               busy_q      <= 1'b1;
               mul_start_q <= 1'b1;
            end
         end else if (mul_done) begin
            mul_start_q <= 1'b1;
            case (state_q)
               StPreM: begin
                  mb_q    <= mul_p;
                  state_q <= StPreX;
               end
               StPreX: begin
                  xb_q    <= mul_p;
                  state_q <= StSqr;
               end
               StSqr: begin
                  xb_q <= mul_p;
                  if (e_q[k_q])          state_q <= StMul;
                  else if (k_q == '0)    state_q <= StPost;
                  else                   k_q     <= k_q - KW'(1);
               end
               StMul: begin
                  xb_q <= mul_p;
                  if (k_q == '0) begin
                     state_q <= StPost;
                  end else begin
                     k_q     <= k_q - KW'(1);
                     state_q <= StSqr;
                  end
               end
               StPost: begin
                  result_q    <= mul_p;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StDone;
                  mul_start_q <= 1'b0;
               end
               default: mul_start_q <= 1'b0;
            endcase
         end
      end
   end

   assign result_o = result_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign error_o  = error_q;

endmodule
